// File: rtl/axi4lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_reg_slave
// Description : AXI4-Lite subordinate exposing NUM_REGS 32-bit strobed R/W
//               registers, with OKAY/SLVERR responses and a flat export.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_reg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_out
);

    localparam int         C_IDX_W       = C_S_AXI_ADDR_WIDTH - 2;
    localparam int         C_STRB_W      = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0] C_RESP_OKAY   = 2'b00;
    localparam logic [1:0] C_RESP_SLVERR = 2'b10;

    logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic                          r_aw_held, r_w_held;
    logic [C_IDX_W-1:0]            r_aw_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_wdata;
    logic [C_STRB_W-1:0]           r_wstrb;
    logic                          r_bvalid;
    logic [1:0]                    r_bresp;
    logic                          r_rvalid;
    logic [1:0]                    r_rresp;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

    logic                          w_aw_fire, w_w_fire, w_ar_fire, w_commit;
    logic [C_IDX_W-1:0]            w_wr_idx;
    logic [31:0]                   w_wr_idx32, w_rd_idx32;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_wr_data, w_rd_data;
    logic [C_STRB_W-1:0]           w_wr_strb;
    logic                          w_wr_hit, w_rd_hit;
    logic                          w_unused;

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Readies depend only on internal state, never on the VALID inputs.
    assign S_AXI_AWREADY = !r_aw_held && !r_bvalid;
    assign S_AXI_WREADY  = !r_w_held  && !r_bvalid;
    assign S_AXI_ARREADY = !r_rvalid;

    assign w_aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_fire  = S_AXI_WVALID  && S_AXI_WREADY;
    assign w_ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;
    assign w_commit  = (w_aw_fire || r_aw_held) && (w_w_fire || r_w_held);

    // A held beat takes priority; otherwise the beat firing this edge is used.
    assign w_wr_idx   = r_aw_held ? r_aw_idx : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_wr_data  = r_w_held  ? r_wdata  : S_AXI_WDATA;
    assign w_wr_strb  = r_w_held  ? r_wstrb  : S_AXI_WSTRB;
    assign w_wr_idx32 = 32'(w_wr_idx);
    assign w_rd_idx32 = 32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
    assign w_wr_hit   = w_wr_idx32 < 32'(NUM_REGS);
    assign w_rd_hit   = w_rd_idx32 < 32'(NUM_REGS);

    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_rd_idx32 == 32'(k)) w_rd_data = r_regs[k];
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= C_RESP_OKAY;
        end else begin
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_hit ? C_RESP_OKAY : C_RESP_SLVERR;
            end else begin
                if (w_aw_fire) begin
                    r_aw_held <= 1'b1;
                    r_aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                end
                if (w_w_fire) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= S_AXI_WDATA;
                    r_wstrb  <= S_AXI_WSTRB;
                end
                if (r_bvalid && S_AXI_BREADY) r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
        end else if (w_commit && w_wr_hit) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                for (int b = 0; b < C_STRB_W; b++) begin
                    if (w_wr_idx32 == 32'(k) && w_wr_strb[b])
                        r_regs[k][8*b +: 8] <= w_wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read samples pre-edge register state, so a same-edge write is not seen.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rvalid <= 1'b0;
            r_rresp  <= C_RESP_OKAY;
            r_rdata  <= '0;
        end else if (w_ar_fire) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_rd_hit ? C_RESP_OKAY : C_RESP_SLVERR;
            r_rdata  <= w_rd_hit ? w_rd_data : '0;
        end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    assign S_AXI_BVALID = r_bvalid;
    assign S_AXI_BRESP  = r_bresp;
    assign S_AXI_RVALID = r_rvalid;
    assign S_AXI_RRESP  = r_rresp;
    assign S_AXI_RDATA  = r_rdata;

    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
            assign reg_out[C_S_AXI_DATA_WIDTH*k +: C_S_AXI_DATA_WIDTH] = r_regs[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/axi4lite_reg_slave.md
# axi4lite_reg_slave

AXI4-Lite subordinate (responder) exposing a bank of 32-bit read/write registers to a bus manager. It is the target end of the same AXI4-Lite link our master VIP drives with single-beat writes and reads. It terminates the five AXI4-Lite channels, applies byte strobes, and returns OKAY or SLVERR responses. The current register contents are exported flat to user logic.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5: byte address width; defines 2^(W-2) word slots.
- NUM_REGS, 4: number of implemented registers, at word slots 0..NUM_REGS-1. Must be ≤ 2^(W-2).

Ports:
- S_AXI_ACLK  in  1  sole clock; all logic on the rising edge.
- S_AXI_ARESETN  in  1  reset, asynchronous and active-low. Deassertion is synchronous to S_AXI_ACLK.
- S_AXI_AWADDR  in  W  write byte address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables; bit n enables WDATA[8n+7:8n].
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake.
- S_AXI_BRESP  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake.
- S_AXI_ARADDR  in  W  read byte address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake.
- reg_out  out  32*NUM_REGS  register contents; reg k is at bits [32k+31:32k].

## Operation
- Decode: word index = ADDR[W-1:2]; ADDR[1:0] is ignored. Index ≥ NUM_REGS is a decode miss.
- Write path:
  - Internal flags aw_held and w_held, plus latched address, data and strobe.
  - AWREADY = !aw_held && !BVALID.
  - WREADY = !w_held && !BVALID.
  - AW and W are accepted independently, in either order or in the same cycle.
  - Commit occurs on the edge where (AW fire or aw_held) and (W fire or w_held) are both true.
  - On a hit: strobed bytes of the register are updated and BRESP=OKAY.
  - On a miss: no register changes and BRESP=SLVERR.
  - At commit: BVALID←1 and both flags clear.
  - BVALID and BRESP hold until BREADY is sampled high, then BVALID←0.
  - No new AW or W is accepted while BVALID=1.
- Read path:
  - ARREADY = !RVALID.
  - On the AR fire edge, RDATA, RRESP and RVALID←1 are registered.
  - Hit: RDATA = register value, RRESP=OKAY.
  - Miss: RDATA = 0, RRESP=SLVERR.
  - RDATA, RRESP and RVALID hold stable until RREADY is sampled high, then RVALID←0.
- Read and write paths are fully independent.
- Read and write committing the same register on the same edge: the read returns the pre-write value.
- WSTRB=0 with a hit: no change, BRESP=OKAY.

## Timing
- Reset (ARESETN low, asynchronous):
  - All registers = 0; reg_out = 0.
  - BVALID = RVALID = 0; BRESP = RRESP = 0; RDATA = 0.
  - aw_held = w_held = 0; consequently AWREADY = WREADY = ARREADY = 1.
  - Reset mid-transaction abandons any held AW/W and any pending B/R without a response.
- Write latency:
  - AW and W handshake together at edge k → BVALID high after edge k; reg_out updated after edge k.
  - W at edge k, AW at edge k+3 → commit at edge k+3.
- Write throughput: with BREADY tied high, one write per 2 cycles (BVALID cycle, then ready again).
- Read latency: AR fire at edge k → RVALID and RDATA valid after edge k. With RREADY tied high, one read per 2 cycles.
- READY outputs are combinational from internal state only, never from VALID inputs.

## Test plan
- Reset, then write 0x1, 0x2, 0x3, 0x4 to 0x00, 0x04, 0x08, 0x0C (WSTRB=4'hF) → each BRESP=00. Reads of the same addresses → RDATA 0x1..0x4, RRESP=00; reg_out = {4,3,2,1}.
- Reg0=0x00000001; write 0xAABBCCDD to 0x00 with WSTRB=4'b0101 → reg0=0x00BB00DD. Then write 0x12345678 with WSTRB=0 → reg0 unchanged, BRESP=00.
- Write ordering:
  - W presented 3 cycles before AW → WREADY drops after the W fire; commit on the AW edge.
  - AW-before-W case → same register result.
  - Both in the same cycle → BVALID on the next cycle.
- Back-pressure:
  - BREADY low for 5 cycles → BVALID/BRESP stable; AWREADY = WREADY = 0 throughout.
  - RREADY low for 5 cycles → RDATA stable, ARREADY = 0.
- Decode miss: write 0xDEADBEEF to 0x10 → BRESP=10 and no reg_out change. Read 0x1C → RDATA=0, RRESP=10.
- Collision and reset:
  - Read of 0x04 and committing write of 0x55 to 0x04 on the same edge → RDATA = old value; next read → 0x55.
  - ARESETN low while BVALID=1 → BVALID=0 immediately, registers = 0.
